// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and constants for the CAN transmit bit serializer
package can_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SEND  = 2'd2
    } tx_state_e;

    localparam int   STUFF_RUN = 5;
    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/can_bit_stuffer.sv
// rtl/can_bit_stuffer.sv - run-length tracker and stuff-bit insertion decision
module can_bit_stuffer
    import can_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             push_bit,
    input  logic [LEN_W-1:0] last_idx,
    input  logic [LEN_W-1:0] stuff_len,
    output logic             insert,
    output logic             stuff_bit
);

    logic [2:0] run_q, run_d;
    logic       last_q, last_d;

    // Runs saturate so long unstuffed tails cannot wrap back onto STUFF_RUN.
    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (clear) begin
            run_d  = '0;
            last_d = RECESSIVE;
        end else if (push) begin
            last_d = push_bit;
            if (run_q == 3'd0 || push_bit != last_q) begin
                run_d = 3'd1;
            end else if (run_q != 3'd7) begin
                run_d = run_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            last_q <= RECESSIVE;
        end else begin
            run_q  <= run_d;
            last_q <= last_d;
        end
    end

    assign insert    = (run_q == 3'(STUFF_RUN)) && (last_idx < stuff_len);
    assign stuff_bit = ~last_q;

endmodule

// File: rtl/can_tx_bitstream.sv
// rtl/can_tx_bitstream.sv - CAN frame serializer with bit stuffing and readback checks
module can_tx_bitstream
    import can_pkg::*;
#(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [MAX_BITS-1:0] frame_bits,
    input  logic [LEN_W-1:0]    frame_len,
    input  logic [LEN_W-1:0]    stuff_len,
    input  logic [LEN_W-1:0]    arb_len,
    input  logic [LEN_W-1:0]    ack_pos,
    input  logic                bit_end,
    input  logic                sample_point,
    input  logic                rx,
    output logic                tx,
    output logic                busy,
    output logic                done,
    output logic                ack_ok,
    output logic                arb_lost,
    output logic                bit_err
);

    tx_state_e           state_q, state_d;
    logic [MAX_BITS-1:0] sh_q, sh_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    flen_q, flen_d, slen_q, slen_d, alen_q, alen_d, apos_q, apos_d;
    logic                is_stuff_q, is_stuff_d;
    logic                tx_q, tx_d, done_q, done_d, ack_ok_q, ack_ok_d;
    logic                arb_lost_q, arb_lost_d, bit_err_q, bit_err_d;
    logic                st_clear, st_push, st_push_bit, st_insert, st_stuff_bit;
    logic                check_fail;

    can_bit_stuffer #(.LEN_W(LEN_W)) u_stuffer (
        .clk       (clk),
        .rst       (rst),
        .clear     (st_clear),
        .push      (st_push),
        .push_bit  (st_push_bit),
        .last_idx  (idx_q),
        .stuff_len (slen_q),
        .insert    (st_insert),
        .stuff_bit (st_stuff_bit)
    );

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        idx_d       = idx_q;
        flen_d      = flen_q;
        slen_d      = slen_q;
        alen_d      = alen_q;
        apos_d      = apos_q;
        is_stuff_d  = is_stuff_q;
        tx_d        = tx_q;
        ack_ok_d    = ack_ok_q;
        done_d      = 1'b0;
        arb_lost_d  = 1'b0;
        bit_err_d   = 1'b0;
        st_clear    = 1'b0;
        st_push     = 1'b0;
        st_push_bit = tx_q;
        check_fail  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = RECESSIVE;
                if (frame_valid) begin
                    sh_d       = frame_bits;
                    flen_d     = (frame_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : frame_len;
                    slen_d     = stuff_len;
                    alen_d     = arb_len;
                    apos_d     = ack_pos;
                    idx_d      = '0;
                    is_stuff_d = 1'b0;
                    ack_ok_d   = 1'b0;
                    st_clear   = 1'b1;
                    state_d    = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (bit_end) begin
                    if (flen_q == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tx_d        = sh_q[0];
                        sh_d        = sh_q >> 1;
                        idx_d       = '0;
                        is_stuff_d  = 1'b0;
                        st_push     = 1'b1;
                        st_push_bit = sh_q[0];
                        state_d     = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                // The readback check on the current bit wins over a coincident advance.
                if (sample_point) begin
                    if (idx_q == apos_q && !is_stuff_q) begin
                        ack_ok_d = ~rx;
                    end else if (tx_q == RECESSIVE && rx == DOMINANT && idx_q < alen_q && !is_stuff_q) begin
                        arb_lost_d = 1'b1;
                        check_fail = 1'b1;
                    end else if (rx != tx_q) begin
                        bit_err_d  = 1'b1;
                        check_fail = 1'b1;
                    end
                end
                if (check_fail) begin
                    tx_d    = RECESSIVE;
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    if (st_insert) begin
                        tx_d        = st_stuff_bit;
                        is_stuff_d  = 1'b1;
                        st_push     = 1'b1;
                        st_push_bit = st_stuff_bit;
                    end else if (({1'b0, idx_q} + 1'b1) < {1'b0, flen_q}) begin
                        tx_d        = sh_q[0];
                        sh_d        = sh_q >> 1;
                        idx_d       = idx_q + 1'b1;
                        is_stuff_d  = 1'b0;
                        st_push     = 1'b1;
                        st_push_bit = sh_q[0];
                    end else begin
                        tx_d    = RECESSIVE;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = RECESSIVE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            idx_q      <= '0;
            flen_q     <= '0;
            slen_q     <= '0;
            alen_q     <= '0;
            apos_q     <= '0;
            is_stuff_q <= 1'b0;
            tx_q       <= RECESSIVE;
            done_q     <= 1'b0;
            ack_ok_q   <= 1'b0;
            arb_lost_q <= 1'b0;
            bit_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            idx_q      <= idx_d;
            flen_q     <= flen_d;
            slen_q     <= slen_d;
            alen_q     <= alen_d;
            apos_q     <= apos_d;
            is_stuff_q <= is_stuff_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            ack_ok_q   <= ack_ok_d;
            arb_lost_q <= arb_lost_d;
            bit_err_q  <= bit_err_d;
        end
    end

    assign frame_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx          = tx_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign arb_lost    = arb_lost_q;
    assign bit_err     = bit_err_q;

endmodule

// File: tb/tb_can_tx_bitstream.sv
// tb/tb_can_tx_bitstream.sv - directed self-checking bench for can_tx_bitstream
module tb_can_tx_bitstream;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_valid = 1'b0;
    logic         frame_ready;
    logic [127:0] frame_bits = '0;
    logic [7:0]   frame_len = '0, stuff_len = '0, arb_len = '0, ack_pos = 8'hFF;
    logic         bit_end = 1'b0, sample_point = 1'b0, rx = 1'b1;
    logic         tx, busy, done, ack_ok, arb_lost, bit_err;

    int n_checks = 0;
    int n_fail   = 0;

    can_tx_bitstream #(.MAX_BITS(128), .LEN_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .frame_bits   (frame_bits),
        .frame_len    (frame_len),
        .stuff_len    (stuff_len),
        .arb_len      (arb_len),
        .ack_pos      (ack_pos),
        .bit_end      (bit_end),
        .sample_point (sample_point),
        .rx           (rx),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .ack_ok       (ack_ok),
        .arb_lost     (arb_lost),
        .bit_err      (bit_err)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [127:0] bits, input logic [7:0] len, input logic [7:0] slen,
                               input logic [7:0] alen, input logic [7:0] apos);
        frame_bits  = bits;
        frame_len   = len;
        stuff_len   = slen;
        arb_len     = alen;
        ack_pos     = apos;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    // Drives up to max_be bit_ends with rx echoing tx; reports which bit_end produced done.
    task automatic run_echo(input int max_be, input bit coinc, output int n_done, output logic [63:0] seq);
        n_done = 0;
        seq    = '0;
        for (int i = 0; i < max_be; i++) begin
            if (coinc && i > 0) begin
                rx           = tx;
                sample_point = 1'b1;
            end
            bit_end = 1'b1;
            @(negedge clk);
            bit_end      = 1'b0;
            sample_point = 1'b0;
            if (done) begin
                n_done = i + 1;
                break;
            end
            seq[i] = tx;
            if (!coinc) begin
                @(negedge clk);
                rx           = tx;
                sample_point = 1'b1;
                @(negedge clk);
                sample_point = 1'b0;
            end
            @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic pulse_be();
        bit_end = 1'b1;
        @(negedge clk);
        bit_end = 1'b0;
    endtask

    task automatic pulse_sp(input logic rxv);
        rx           = rxv;
        sample_point = 1'b1;
        @(negedge clk);
        sample_point = 1'b0;
        rx           = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          nd;
        logic [63:0] seq;

        repeat (3) @(negedge clk);
        expect_eq("rst_tx", tx, 1);
        expect_eq("rst_ready", frame_ready, 1);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_pulses", {done, ack_ok, arb_lost, bit_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // A5, no stuffing needed
        start_frame(128'hA5, 8, 8, 0, 8'hFF);
        expect_eq("acc_ready", frame_ready, 0);
        expect_eq("acc_busy", busy, 1);
        run_echo(20, 0, nd, seq);
        expect_eq("a5_seq", seq[7:0], 8'hA5);
        expect_eq("a5_done_be", nd, 9);
        expect_eq("a5_ready", frame_ready, 1);
        @(negedge clk);
        expect_eq("a5_done_1cyc", done, 0);

        // all zero, stuffed region covers the whole frame
        start_frame(128'h0, 8, 8, 0, 8'hFF);
        run_echo(20, 0, nd, seq);
        expect_eq("z_stuff_seq", seq[8:0], 9'h020);
        expect_eq("z_stuff_done_be", nd, 10);

        start_frame(128'h0, 8, 0, 0, 8'hFF);
        run_echo(20, 0, nd, seq);
        expect_eq("z_nostuff_seq", seq[8:0], 9'h000);
        expect_eq("z_nostuff_done_be", nd, 9);

        // lost arbitration on recessive bit 3
        start_frame(128'h8, 20, 0, 11, 8'hFF);
        run_echo(3, 0, nd, seq);
        expect_eq("arb_pre_done", nd, 0);
        pulse_be();
        expect_eq("arb_bit3_tx", tx, 1);
        @(negedge clk);
        pulse_sp(1'b0);
        expect_eq("arb_lost", arb_lost, 1);
        expect_eq("arb_no_biterr", bit_err, 0);
        expect_eq("arb_ready", frame_ready, 1);
        @(negedge clk);
        expect_eq("arb_lost_1cyc", arb_lost, 0);
        expect_eq("arb_tx", tx, 1);

        // bit error on dominant bit 15
        start_frame(128'h0, 20, 0, 11, 8'hFF);
        run_echo(15, 0, nd, seq);
        pulse_be();
        expect_eq("berr_bit15_tx", tx, 0);
        @(negedge clk);
        pulse_sp(1'b1);
        expect_eq("berr_pulse", bit_err, 1);
        expect_eq("berr_no_arb", arb_lost, 0);
        expect_eq("berr_ready", frame_ready, 1);
        expect_eq("berr_tx", tx, 1);

        // recessive ACK slot read back dominant: acknowledged, no error
        start_frame(128'h8000, 17, 0, 11, 8'd15);
        run_echo(15, 0, nd, seq);
        pulse_be();
        @(negedge clk);
        pulse_sp(1'b0);
        expect_eq("ack_no_err", {arb_lost, bit_err}, 0);
        expect_eq("ack_busy", busy, 1);
        run_echo(5, 0, nd, seq);
        expect_eq("ack_done_be", nd, 2);
        expect_eq("ack_ok", ack_ok, 1);

        // reset in the middle of bit 20
        start_frame(128'h0, 30, 0, 0, 8'hFF);
        run_echo(21, 0, nd, seq);
        expect_eq("pre_rst_tx", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_eq("mrst_tx", tx, 1);
        expect_eq("mrst_busy", busy, 0);
        expect_eq("mrst_ready", frame_ready, 1);
        expect_eq("mrst_ack", ack_ok, 0);
        start_frame(128'hA5, 8, 8, 0, 8'hFF);
        run_echo(20, 0, nd, seq);
        expect_eq("post_rst_seq", seq[7:0], 8'hA5);
        expect_eq("post_rst_done_be", nd, 9);

        // second offer while busy, strobes coincident
        start_frame(128'h0F, 8, 0, 0, 8'hFF);
        frame_bits  = 128'hF0;
        frame_len   = 8'd4;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        run_echo(20, 1, nd, seq);
        expect_eq("coinc_seq", seq[7:0], 8'h0F);
        expect_eq("coinc_done_be", nd, 9);
        @(negedge clk);
        expect_eq("coinc_idle", busy, 0);

        // failing check and bit_end together: no advance to the dominant next bit
        start_frame(128'h2, 8, 0, 0, 8'hFF);
        pulse_be();
        expect_eq("cba_bit0", tx, 0);
        rx = 1'b0; sample_point = 1'b1; bit_end = 1'b1;
        @(negedge clk);
        sample_point = 1'b0; bit_end = 1'b0; rx = 1'b1;
        expect_eq("cba_bit1", tx, 1);
        rx = 1'b0; sample_point = 1'b1; bit_end = 1'b1;
        @(negedge clk);
        sample_point = 1'b0; bit_end = 1'b0; rx = 1'b1;
        expect_eq("cba_biterr", bit_err, 1);
        expect_eq("cba_tx", tx, 1);
        expect_eq("cba_ready", frame_ready, 1);
        expect_eq("cba_no_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
